// File: rtl/calc_pkg.sv
// Shared command/response encodings and the default request record for the
// N-port calculator scheduler.
package calc_pkg;

    localparam int CALC_DATA_W = 32;
    localparam int CALC_TAG_W  = 2;
    localparam int CALC_CMD_W  = 4;

    localparam int CMD_NOP = 0;
    localparam int CMD_ADD = 1;
    localparam int CMD_SUB = 2;
    localparam int CMD_SHL = 5;
    localparam int CMD_SHR = 6;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_OVF  = 2'd2,
        RESP_INV  = 2'd3
    } resp_e;

    typedef struct packed {
        logic [CALC_CMD_W-1:0]  cmd;
        logic [CALC_TAG_W-1:0]  tag;
        logic [CALC_DATA_W-1:0] op1;
        logic [CALC_DATA_W-1:0] op2;
    } req_t;

endpackage

// File: rtl/calc_port_sched_if.sv
// Request/response bundle for calc_port_sched; per-port fields are packed
// side by side, port p at [p*W +: W].
interface calc_port_sched_if #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 2,
    parameter int CMD_W   = 4
);
    logic [N_PORTS*CMD_W-1:0]  req_cmd;
    logic [N_PORTS*DATA_W-1:0] req_data;
    logic [N_PORTS*TAG_W-1:0]  req_tag;
    logic [N_PORTS-1:0]        req_busy;
    logic [N_PORTS*2-1:0]      out_resp;
    logic [N_PORTS*DATA_W-1:0] out_data;
    logic [N_PORTS*TAG_W-1:0]  out_tag;

    modport master (
        output req_cmd, req_data, req_tag,
        input  req_busy, out_resp, out_data, out_tag
    );

    modport slave (
        input  req_cmd, req_data, req_tag,
        output req_busy, out_resp, out_data, out_tag
    );
endinterface

// File: rtl/calc_port_fifo.sv
// Synchronous FIFO holding one port's captured requests; same-cycle push and
// pop is allowed and leaves the count unchanged.
module calc_port_fifo
    import calc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = req_t
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; pointers and count alone say which entries are live.
    always_ff @(posedge c_clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/calc_port_sched.sv
// N-port calculator front-end: per-port two-cycle capture into private FIFOs,
// round-robin pick of one request per cycle, shared ALU, registered replies.
module calc_port_sched
    import calc_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 2,
    parameter int CMD_W   = 4
) (
    input  logic            c_clk,
    input  logic            reset,
    calc_port_sched_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int RR_W  = $clog2(N_PORTS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OP2  = 1'b1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } entry_t;

    entry_t             fifo_out [N_PORTS];
    logic [CNT_W-1:0]   count    [N_PORTS];
    logic [N_PORTS-1:0] fifo_full;
    logic [N_PORTS-1:0] fifo_empty;
    logic [N_PORTS-1:0] pop;

    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    grant;
    logic               grant_valid;
    int                 idx;

    entry_t             sel;
    resp_e              alu_resp;
    logic [DATA_W-1:0]  alu_data;
    logic [DATA_W:0]    sum;

    logic [N_PORTS*2-1:0]      resp_q;
    logic [N_PORTS*DATA_W-1:0] data_q;
    logic [N_PORTS*TAG_W-1:0]  tag_q;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [0:0]        state;
        logic [CMD_W-1:0]  cmd;
        logic [CMD_W-1:0]  hold_cmd;
        logic [TAG_W-1:0]  hold_tag;
        logic [DATA_W-1:0] hold_op1;
        entry_t            wr_entry;

        assign cmd = bus.req_cmd[p*CMD_W +: CMD_W];

        // Busy counts the entry still being captured so an accepted cmd always finds room.
        assign bus.req_busy[p] = fifo_full[p] ||
                                 (state == ST_OP2 && count[p] == CNT_W'(DEPTH-1));

        assign wr_entry = '{cmd: hold_cmd, tag: hold_tag, op1: hold_op1,
                            op2: bus.req_data[p*DATA_W +: DATA_W]};

        always_ff @(posedge c_clk) begin
            if (reset) begin
                state <= ST_IDLE;
            end else if (state == ST_OP2) begin
                state <= ST_IDLE;
            end else if (cmd != '0 && !bus.req_busy[p]) begin
                state    <= ST_OP2;
                hold_cmd <= cmd;
                hold_tag <= bus.req_tag[p*TAG_W +: TAG_W];
                hold_op1 <= bus.req_data[p*DATA_W +: DATA_W];
            end
        end

        calc_port_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
            .c_clk     (c_clk),
            .reset     (reset),
            .push      (state == ST_OP2),
            .push_data (wr_entry),
            .pop       (pop[p]),
            .pop_data  (fifo_out[p]),
            .full      (fifo_full[p]),
            .empty     (fifo_empty[p]),
            .count     (count[p])
        );
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        pop         = '0;
        idx         = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % N_PORTS;
            if (!grant_valid && !fifo_empty[idx]) begin
                grant_valid = 1'b1;
                grant       = RR_W'(idx);
            end
        end
        if (grant_valid) pop[grant] = 1'b1;
    end

    assign sel = fifo_out[grant];

    always_comb begin
        alu_resp = RESP_INV;
        alu_data = '0;
        sum      = {1'b0, sel.op1} + {1'b0, sel.op2};
        case (32'(sel.cmd))
            CMD_ADD: begin
                alu_resp = sum[DATA_W] ? RESP_OVF : RESP_OK;
                alu_data = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
            end
            CMD_SUB: begin
                if (sel.op1 < sel.op2) begin
                    alu_resp = RESP_OVF;
                end else begin
                    alu_resp = RESP_OK;
                    alu_data = sel.op1 - sel.op2;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = sel.op1 << sel.op2[SH_W-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = sel.op1 >> sel.op2[SH_W-1:0];
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; the clear-then-set pattern below relies on last-NBA-wins.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            rr_ptr <= '0;
            resp_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            resp_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
            if (grant_valid) begin
                resp_q[int'(grant)*2      +: 2]      <= alu_resp;
                data_q[int'(grant)*DATA_W +: DATA_W] <= alu_data;
                tag_q [int'(grant)*TAG_W  +: TAG_W]  <= sel.tag;
                rr_ptr <= (grant == RR_W'(N_PORTS-1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign bus.out_resp = resp_q;
    assign bus.out_data = data_q;
    assign bus.out_tag  = tag_q;

endmodule

// File: tb/tb_calc_port_sched.sv
// Self-checking bench for calc_port_sched: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_calc_port_sched;
    import calc_pkg::*;

    localparam int N_PORTS = 4;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 2;
    localparam int CMD_W   = 4;
    localparam longint unsigned MASK = (64'd1 << DATA_W) - 1;

    logic c_clk = 1'b0;
    logic reset = 1'b1;

    calc_port_sched_if #(.N_PORTS(N_PORTS), .DATA_W(DATA_W), .TAG_W(TAG_W), .CMD_W(CMD_W)) bus ();

    calc_port_sched #(.N_PORTS(N_PORTS), .DEPTH(DEPTH), .DATA_W(DATA_W),
                      .TAG_W(TAG_W), .CMD_W(CMD_W)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        int unsigned      cmd;
        int unsigned      tag;
        longint unsigned  op1;
        longint unsigned  op2;
    } mreq_t;

    // Reference model: accepted requests per port, pending capture, rr pointer.
    mreq_t           q       [N_PORTS][$];
    bit              cap     [N_PORTS];
    mreq_t           cap_req [N_PORTS];
    int              rr;
    int unsigned     exp_resp [N_PORTS];
    longint unsigned exp_data [N_PORTS];
    int unsigned     exp_tag  [N_PORTS];
    int              acc      [N_PORTS];
    int              resp_cnt [N_PORTS];
    bit              saw_busy [N_PORTS];

    int unsigned     cmd_in  [N_PORTS];
    longint unsigned data_in [N_PORTS];
    int unsigned     tag_in  [N_PORTS];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic void model_alu(input mreq_t r, output int unsigned resp,
                                      output longint unsigned data);
        resp = 3;
        data = 0;
        case (r.cmd)
            1: if (r.op1 + r.op2 > MASK) resp = 2;
               else begin resp = 1; data = r.op1 + r.op2; end
            2: if (r.op1 < r.op2) resp = 2;
               else begin resp = 1; data = r.op1 - r.op2; end
            5: begin resp = 1; data = (r.op1 << (r.op2 % DATA_W)) & MASK; end
            6: begin resp = 1; data = r.op1 >> (r.op2 % DATA_W); end
            default: ;
        endcase
    endfunction

    function automatic longint unsigned rand_op();
        case ($urandom_range(0, 3))
            0:       return longint'($urandom_range(0, 40));
            1:       return 64'hFFFF_FFF0 + longint'($urandom_range(0, 15));
            default: return longint'($urandom);
        endcase
    endfunction

    function automatic int unsigned rand_cmd();
        int unsigned pick [7] = '{1, 2, 5, 6, 1, 2, 9};
        return pick[$urandom_range(0, 6)];
    endfunction

    // One clock cycle: called at a falling edge with inputs in cmd_in/data_in/tag_in.
    task automatic tick();
        bit          mbusy [N_PORTS];
        logic [N_PORTS-1:0] mbusy_v;
        int          g;
        mreq_t       r;
        int unsigned rs;
        longint unsigned dd;
        for (int p = 0; p < N_PORTS; p++) begin
            bus.req_cmd [p*CMD_W  +: CMD_W]  = CMD_W'(cmd_in[p]);
            bus.req_data[p*DATA_W +: DATA_W] = DATA_W'(data_in[p]);
            bus.req_tag [p*TAG_W  +: TAG_W]  = TAG_W'(tag_in[p]);
        end
        #1;
        for (int p = 0; p < N_PORTS; p++) begin
            mbusy[p]   = (q[p].size() + int'(cap[p])) >= DEPTH;
            mbusy_v[p] = mbusy[p];
            if (bus.req_busy[p] === 1'b1) saw_busy[p] = 1'b1;
        end
        if (!reset) check("req_busy", bus.req_busy, mbusy_v);

        for (int p = 0; p < N_PORTS; p++) begin
            exp_resp[p] = 0; exp_data[p] = 0; exp_tag[p] = 0;
        end
        if (reset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                q[p].delete();
                cap[p] = 1'b0;
            end
            rr = 0;
        end else begin
            g = -1;
            for (int i = 0; i < N_PORTS; i++)
                if (g < 0 && q[(rr + i) % N_PORTS].size() > 0) g = (rr + i) % N_PORTS;
            if (g >= 0) begin
                r = q[g].pop_front();
                model_alu(r, rs, dd);
                exp_resp[g] = rs; exp_data[g] = dd; exp_tag[g] = r.tag;
                rr = (g + 1) % N_PORTS;
            end
            for (int p = 0; p < N_PORTS; p++) begin
                if (cap[p]) begin
                    cap_req[p].op2 = data_in[p];
                    q[p].push_back(cap_req[p]);
                    cap[p] = 1'b0;
                end else if (cmd_in[p] != 0 && !mbusy[p]) begin
                    cap_req[p] = '{cmd: cmd_in[p], tag: tag_in[p], op1: data_in[p], op2: 0};
                    cap[p] = 1'b1;
                    acc[p]++;
                end
            end
        end

        @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 0; p < N_PORTS; p++) begin
            check($sformatf("resp p%0d", p), bus.out_resp[p*2 +: 2], exp_resp[p]);
            check($sformatf("data p%0d", p), bus.out_data[p*DATA_W +: DATA_W], exp_data[p]);
            check($sformatf("tag p%0d", p),  bus.out_tag[p*TAG_W +: TAG_W], exp_tag[p]);
            if (bus.out_resp[p*2 +: 2] !== 2'd0) resp_cnt[p]++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                cmd_in[p] = 0; data_in[p] = 0; tag_in[p] = 0;
            end
            tick();
        end
    endtask

    // Two-cycle request on one port while the others stay quiet.
    task automatic issue(input int p, input int unsigned cmd, input longint unsigned op1,
                         input longint unsigned op2, input int unsigned tag);
        for (int i = 0; i < N_PORTS; i++) begin
            cmd_in[i] = 0; data_in[i] = 0; tag_in[i] = 0;
        end
        cmd_in[p] = cmd; data_in[p] = op1; tag_in[p] = tag;
        tick();
        cmd_in[p] = 0; data_in[p] = op2; tag_in[p] = 0;
        tick();
    endtask

    // Random traffic: enabled ports offer a cmd on every idle cycle, busy or not.
    task automatic traffic(input logic [N_PORTS-1:0] en, input int n);
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                tag_in[p] = $urandom_range(0, 3);
                if (cap[p]) begin
                    cmd_in[p]  = $urandom_range(0, 15);
                    data_in[p] = rand_op();
                end else if (en[p]) begin
                    cmd_in[p]  = rand_cmd();
                    data_in[p] = rand_op();
                end else begin
                    cmd_in[p]  = 0;
                    data_in[p] = 0;
                end
            end
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        int r0;
        int a0;
        for (int p = 0; p < N_PORTS; p++) begin
            cmd_in[p] = 0; data_in[p] = 0; tag_in[p] = 0;
            acc[p] = 0; resp_cnt[p] = 0; saw_busy[p] = 1'b0; cap[p] = 1'b0;
        end
        rr = 0;
        @(negedge c_clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("reset busy", bus.req_busy, '0);
        check("reset resp", bus.out_resp, '0);

        // 1: single ADD, answer two cycles after operand2
        issue(0, CMD_ADD, 5, 7, 1);
        check("s1 early resp", bus.out_resp, '0);
        idle(1);
        check("s1 resp", bus.out_resp[1:0], 1);
        check("s1 data", bus.out_data[31:0], 12);
        check("s1 tag", bus.out_tag[1:0], 1);
        check("s1 others", bus.out_resp[7:2], 0);

        // 2: overflow, underflow, invalid, shift-amount truncation
        issue(2, CMD_ADD, 64'hFFFF_FFFF, 1, 2);
        idle(1);
        check("s2 add ovf resp", bus.out_resp[5:4], 2);
        check("s2 add ovf data", bus.out_data[95:64], 0);
        issue(1, CMD_SUB, 3, 4, 3);
        idle(1);
        check("s2 sub resp", bus.out_resp[3:2], 2);
        issue(3, 9, 11, 12, 0);
        idle(1);
        check("s2 inv resp", bus.out_resp[7:6], 3);
        check("s2 inv data", bus.out_data[127:96], 0);
        issue(0, CMD_SHL, 1, 33, 2);
        idle(1);
        check("s2 shl data", bus.out_data[31:0], 2);
        issue(1, CMD_SHR, 32'h8000_0000, 31, 1);
        idle(1);
        check("s2 shr data", bus.out_data[63:32], 1);

        // 3: all ports at once from rr=0, then a second round
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                cmd_in[p] = CMD_ADD; data_in[p] = p; tag_in[p] = p;
            end
            tick();
            for (int p = 0; p < N_PORTS; p++) begin
                cmd_in[p] = 0; data_in[p] = 10; tag_in[p] = 0;
            end
            tick();
            for (int k = 0; k < N_PORTS; k++) begin
                idle(1);
                check($sformatf("s3 order r%0d k%0d", round, k), bus.out_resp, 8'd1 << (2*k));
            end
        end

        // 4: port1 runs into busy with the arbiter shared by all ports
        do_reset();
        r0 = resp_cnt[1];
        a0 = acc[1];
        saw_busy[1] = 1'b0;
        traffic(4'b1111, 30);
        idle(N_PORTS*DEPTH + 4);
        check("s4 busy seen", saw_busy[1], 1);
        check("s4 port1 responses", resp_cnt[1] - r0, acc[1] - a0);

        // 5: reset with port0 mid-capture and port1 holding a backlog
        do_reset();
        for (int k = 0; k < 60; k++) begin
            if (cap[0] && q[1].size() >= 3) break;
            traffic(4'b1111, 1);
        end
        do_reset();
        check("s5 busy after reset", bus.req_busy, '0);
        check("s5 resp after reset", bus.out_resp, '0);
        idle(N_PORTS*DEPTH + 2);
        issue(0, CMD_ADD, 2, 2, 3);
        idle(1);
        check("s5 add resp", bus.out_resp[1:0], 1);
        check("s5 add data", bus.out_data[31:0], 4);

        // 6: port0 back-to-back at full rate
        r0 = resp_cnt[0];
        for (int k = 0; k < 20; k++) begin
            issue(0, rand_cmd(), rand_op(), rand_op(), k % 4);
            check("s6 busy", bus.req_busy[0], 0);
        end
        idle(3);
        check("s6 responses", resp_cnt[0] - r0, 20);

        // random mixed traffic
        for (int k = 0; k < 20; k++) traffic(4'($urandom_range(0, 15)), 10);
        idle(N_PORTS*DEPTH + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
